// File: rtl/gpu_rect_sched.sv
// Round-robin rectangle-fill command scheduler for the gpu_fill_rect engine.
// Optional clipping/rejection of off-screen commands: define GPU_RECT_CLIP_EN.

module gpu_rect_norm #(
  parameter int WB = 10,
  parameter int HB = 9
) (
  input  logic [WB-1:0] x1_i,
  input  logic [WB-1:0] x2_i,
  input  logic [HB-1:0] y1_i,
  input  logic [HB-1:0] y2_i,
  output logic [WB-1:0] xlo_o,
  output logic [WB-1:0] xhi_o,
  output logic [HB-1:0] ylo_o,
  output logic [HB-1:0] yhi_o
);
  always_comb begin
    xlo_o = (x2_i < x1_i) ? x2_i : x1_i;
    xhi_o = (x2_i < x1_i) ? x1_i : x2_i;
    ylo_o = (y2_i < y1_i) ? y2_i : y1_i;
    yhi_o = (y2_i < y1_i) ? y1_i : y2_i;
  end
endmodule

module gpu_rect_sched #(
  parameter int COLOR_BITS  = 32,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int WIDTH_BITS  = $clog2(SCREEN_W),
  parameter int HEIGHT_BITS = $clog2(SCREEN_H)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid_i,
  input  logic [WIDTH_BITS-1:0]  req0_x1_i,
  input  logic [WIDTH_BITS-1:0]  req0_x2_i,
  input  logic [HEIGHT_BITS-1:0] req0_y1_i,
  input  logic [HEIGHT_BITS-1:0] req0_y2_i,
  input  logic [COLOR_BITS-1:0]  req0_color_i,
  output logic                   req0_ready_o,
  output logic                   req0_done_o,
  output logic                   req0_err_o,
  input  logic                   req1_valid_i,
  input  logic [WIDTH_BITS-1:0]  req1_x1_i,
  input  logic [WIDTH_BITS-1:0]  req1_x2_i,
  input  logic [HEIGHT_BITS-1:0] req1_y1_i,
  input  logic [HEIGHT_BITS-1:0] req1_y2_i,
  input  logic [COLOR_BITS-1:0]  req1_color_i,
  output logic                   req1_ready_o,
  output logic                   req1_done_o,
  output logic                   req1_err_o,
  output logic [WIDTH_BITS-1:0]  fill_x1_o,
  output logic [WIDTH_BITS-1:0]  fill_x2_o,
  output logic [HEIGHT_BITS-1:0] fill_y1_o,
  output logic [HEIGHT_BITS-1:0] fill_y2_o,
  output logic                   fill_start_o,
  input  logic                   fill_busy_i,
  input  logic                   fill_done_i,
  output logic [COLOR_BITS-1:0]  color_o,
  output logic                   owner_o,
  output logic                   busy_o
);
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DONE} state_t;
  state_t state_q, state_d;

  logic [NUM_REQ-1:0]                  vld, gnt;
  logic [NUM_REQ-1:0][WIDTH_BITS-1:0]  rx1, rx2, nxlo, nxhi;
  logic [NUM_REQ-1:0][HEIGHT_BITS-1:0] ry1, ry2, nylo, nyhi;
  logic [NUM_REQ-1:0][COLOR_BITS-1:0]  rcol;

  assign vld  = {req1_valid_i, req0_valid_i};
  assign rx1  = {req1_x1_i, req0_x1_i};
  assign rx2  = {req1_x2_i, req0_x2_i};
  assign ry1  = {req1_y1_i, req0_y1_i};
  assign ry2  = {req1_y2_i, req0_y2_i};
  assign rcol = {req1_color_i, req0_color_i};

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_norm
    gpu_rect_norm #(.WB(WIDTH_BITS), .HB(HEIGHT_BITS)) u_norm (
      .x1_i (rx1[g]),
      .x2_i (rx2[g]),
      .y1_i (ry1[g]),
      .y2_i (ry2[g]),
      .xlo_o(nxlo[g]),
      .xhi_o(nxhi[g]),
      .ylo_o(nylo[g]),
      .yhi_o(nyhi[g])
    );
  end

  logic                   last_grant_q;
  logic                   owner_q;
  logic [COLOR_BITS-1:0]  color_q;
  logic [WIDTH_BITS-1:0]  fx1_q, fx2_q;
  logic [HEIGHT_BITS-1:0] fy1_q, fy2_q;

  // last_grant_q holds the index granted last; the other port wins a tie.
  always_comb begin
    gnt = '0;
    if (state_q == S_IDLE) begin
      if (vld[0] && (!vld[1] || last_grant_q)) gnt[0] = 1'b1;
      else if (vld[1])                         gnt[1] = 1'b1;
    end
  end

  logic                   sel;
  logic [WIDTH_BITS-1:0]  cx1, cx2;
  logic [HEIGHT_BITS-1:0] cy1, cy2;
  logic                   rej;

  assign sel = gnt[1];

`ifdef GPU_RECT_CLIP_EN
  localparam logic [WIDTH_BITS-1:0]  X_MAX = WIDTH_BITS'(SCREEN_W - 1);
  localparam logic [HEIGHT_BITS-1:0] Y_MAX = HEIGHT_BITS'(SCREEN_H - 1);
`endif

  always_comb begin
    cx1 = nxlo[sel];
    cx2 = nxhi[sel];
    cy1 = nylo[sel];
    cy2 = nyhi[sel];
    rej = 1'b0;
`ifdef GPU_RECT_CLIP_EN
    if (cx2 > X_MAX) cx2 = X_MAX;
    if (cy2 > Y_MAX) cy2 = Y_MAX;
    rej = (cx1 > X_MAX) || (cy1 > Y_MAX);
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|gnt) state_d = rej ? S_DONE : S_START;
      // A 1-pixel fill may finish before the engine ever reports busy.
      S_START: if (fill_done_i)      state_d = S_DONE;
               else if (fill_busy_i) state_d = S_RUN;
      S_RUN:   if (fill_done_i) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      color_q      <= '0;
      fx1_q        <= '0;
      fx2_q        <= '0;
      fy1_q        <= '0;
      fy2_q        <= '0;
    end else begin
      state_q <= state_d;
      if (|gnt) begin
        owner_q <= sel;
        color_q <= rcol[sel];
        fx1_q   <= cx1;
        fx2_q   <= cx2;
        fy1_q   <= cy1;
        fy2_q   <= cy2;
      end
      if (state_q == S_DONE) last_grant_q <= owner_q;
    end
  end

  logic done_any;
  assign done_any = (state_q == S_DONE);

`ifdef GPU_RECT_CLIP_EN
  logic rej_q;
  always_ff @(posedge clk) begin
    if (rst)        rej_q <= 1'b0;
    else if (|gnt)  rej_q <= rej;
  end
  assign req0_err_o = done_any && !owner_q && rej_q;
  assign req1_err_o = done_any &&  owner_q && rej_q;
`else
  assign req0_err_o = 1'b0;
  assign req1_err_o = 1'b0;
`endif

  assign req0_ready_o = gnt[0];
  assign req1_ready_o = gnt[1];
  assign req0_done_o  = done_any && !owner_q;
  assign req1_done_o  = done_any &&  owner_q;
  assign fill_start_o = (state_q == S_START);
  assign busy_o       = (state_q != S_IDLE);
  assign fill_x1_o    = fx1_q;
  assign fill_x2_o    = fx2_q;
  assign fill_y1_o    = fy1_q;
  assign fill_y2_o    = fy2_q;
  assign color_o      = color_q;
  assign owner_o      = owner_q;
endmodule
